// File: rtl/cbb_ecc_enc.sv
// rtl/cbb_ecc_enc.sv - SECDED encoder with valid/ready output and two-entry skid buffer
//
// Purpose: computes EW-1 Hamming check bits plus one overall-parity bit for a
// DW-bit data word and emits the codeword {ecc, data} through a registered
// valid/ready stage (output register + skid register) that sustains one word
// per cycle under backpressure.
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset
//   in_vld    input word valid
//   in_rdy    encoder can accept a word (decoded from state flops, 0 during rst)
//   in_data   DW-bit data word
//   out_vld   codeword valid
//   out_rdy   downstream accepts the codeword
//   out_data  codeword: [DW-1:0] = data, [DW+EW-1:DW] = ecc
//   inj_mask  error-injection XOR mask         (CBB_ECC_ENC_ERR_INJ_EN only)
//   out_inj   codeword carries a nonzero mask  (CBB_ECC_ENC_ERR_INJ_EN only)
//
// Optional feature macro: CBB_ECC_ENC_ERR_INJ_EN
module cbb_ecc_enc #(
  parameter int DW = 32,
  parameter int EW = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [DW-1:0]      in_data,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [DW+EW-1:0]   out_data
`ifdef CBB_ECC_ENC_ERR_INJ_EN
  ,
  input  logic [DW+EW-1:0]   inj_mask,
  output logic               out_inj
`endif
);

  localparam int CW = DW + EW;

  // Data bit j sits at the (j+1)-th integer >= 3 that is not a power of two.
  // Returns the set of data bits whose Hamming position has bit bit_idx set.
  // Powers of two are never adjacent above 2, so a single skip suffices.
  function automatic logic [DW-1:0] ham_mask(input int bit_idx);
    logic [DW-1:0] m;
    int            p;
    m = '0;
    p = 2;
    for (int j = 0; j < DW; j++) begin
      p = p + 1;
      if ((p & (p - 1)) == 0) begin
        p = p + 1;
      end
      m[j] = p[bit_idx];
    end
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // Combinational encoder
  // ---------------------------------------------------------------------------
  logic [EW-2:0] w_ham;
  logic          w_par;
  logic [CW-1:0] w_codeword;
  logic [CW-1:0] w_stored;

  for (genvar gi = 0; gi < EW - 1; gi++) begin : g_ham
    localparam logic [DW-1:0] HMASK = ham_mask(gi);
    assign w_ham[gi] = ^(in_data & HMASK);
  end

  // Overall parity covers data and Hamming bits so a clean codeword is even.
  assign w_par      = ^{in_data, w_ham};
  assign w_codeword = {w_par, w_ham, in_data};

`ifdef CBB_ECC_ENC_ERR_INJ_EN
  logic w_inj;
  assign w_stored = w_codeword ^ inj_mask;
  assign w_inj    = |inj_mask;
`else
  assign w_stored = w_codeword;
`endif

  // ---------------------------------------------------------------------------
  // Output / skid control
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_out_data;
  logic [CW-1:0] r_skid_data;
  logic          w_accept;
  logic          w_pop;
  logic          w_load_out_in;
  logic          w_load_out_skid;
  logic          w_load_skid;

  // in_rdy comes from the state flops only; rst gates it so nothing is
  // accepted on a reset edge.
  assign in_rdy   = (r_state != S_FULL) & ~rst;
  assign out_vld  = (r_state != S_EMPTY);
  assign out_data = r_out_data;

  assign w_accept = in_vld & in_rdy;
  assign w_pop    = out_vld & out_rdy;

  always_comb begin
    w_state_nxt     = r_state;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_nxt   = S_ONE;
          w_load_out_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && w_pop) begin
          w_load_out_in = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = S_FULL;
          w_load_skid = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_pop) begin
          w_state_nxt     = S_ONE;
          w_load_out_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_out_data  <= '0;
      r_skid_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_out_in) begin
        r_out_data <= w_stored;
      end else if (w_load_out_skid) begin
        r_out_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_data <= w_stored;
      end
    end
  end

`ifdef CBB_ECC_ENC_ERR_INJ_EN
  // The injection flag travels alongside its codeword through the skid slot.
  logic r_out_inj;
  logic r_skid_inj;

  assign out_inj = r_out_inj;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_inj  <= 1'b0;
      r_skid_inj <= 1'b0;
    end else begin
      if (w_load_out_in) begin
        r_out_inj <= w_inj;
      end else if (w_load_out_skid) begin
        r_out_inj <= r_skid_inj;
      end
      if (w_load_skid) begin
        r_skid_inj <= w_inj;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cbb_ecc_enc.sv
// tb/tb_cbb_ecc_enc.sv - self-checking bench for cbb_ecc_enc
module tb_cbb_ecc_enc;

  localparam int DW = 32;
  localparam int EW = 7;
  localparam int CW = DW + EW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_vld;
  logic          in_rdy;
  logic [DW-1:0] in_data;
  logic          out_vld;
  logic          out_rdy;
  logic [CW-1:0] out_data;
  logic [CW-1:0] inj_mask;
`ifdef CBB_ECC_ENC_ERR_INJ_EN
  logic          out_inj;
`endif

  always #5 clk = ~clk;

  cbb_ecc_enc #(.DW(DW), .EW(EW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data)
`ifdef CBB_ECC_ENC_ERR_INJ_EN
    ,
    .inj_mask (inj_mask),
    .out_inj  (out_inj)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Hamming position of each data bit: the non-powers of two from 3 upward.
  int hpos[DW];

  task automatic fill_hpos();
    int n;
    n = 0;
    for (int v = 3; n < DW; v++) begin
      if ($countones(v) != 1) begin
        hpos[n] = v;
        n++;
      end
    end
  endtask

  // Check bits = XOR of the positions of all set data bits; top bit makes total parity even.
  function automatic logic [CW-1:0] ref_enc(input logic [DW-1:0] d);
    int            syn;
    logic [EW-2:0] h;
    logic          p;
    syn = 0;
    for (int j = 0; j < DW; j++) if (d[j]) syn = syn ^ hpos[j];
    h = syn[EW-2:0];
    p = (^d) ^ (^h);
    return {p, h, d};
  endfunction

  task automatic ref_dec(input logic [CW-1:0] cw, output logic [DW-1:0] d,
                         output bit sec, output bit ded);
    int syn;
    syn = 0;
    syn[EW-2:0] = cw[CW-2:DW];
    for (int j = 0; j < DW; j++) if (cw[j]) syn = syn ^ hpos[j];
    d   = cw[DW-1:0];
    sec = 1'b0;
    ded = 1'b0;
    if (^cw) begin
      sec = 1'b1;
      for (int j = 0; j < DW; j++) if (hpos[j] == syn) d[j] = ~d[j];
    end else if (syn != 0) begin
      ded = 1'b1;
    end
  endtask

  typedef struct {
    logic [CW-1:0] cw;
    logic [DW-1:0] data;
    logic          inj;
    int            nerr;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] rx[$];
  bit            model_on = 1'b0;

  // One clock: drive inputs, compare DUT against the queue model, advance model.
  task automatic cycle(input logic vld, input logic [DW-1:0] d, input logic ordy,
                       input logic r, input logic [CW-1:0] m, output bit acc, output bit pop);
    logic [DW-1:0] dd;
    bit            s;
    bit            e;
    ent_t          ent;
    in_vld   = vld;
    in_data  = d;
    out_rdy  = ordy;
    rst      = r;
    inj_mask = m;
    #1;
    acc = vld && !r && (q.size() < 2);
    pop = !r && (q.size() > 0) && ordy;
    if (model_on) begin
      check("in_rdy", in_rdy, (!r && q.size() < 2));
      check("out_vld", out_vld, (q.size() > 0));
      if (q.size() > 0) begin
        check("out_data", out_data, q[0].cw);
`ifdef CBB_ECC_ENC_ERR_INJ_EN
        check("out_inj", out_inj, q[0].inj);
`endif
        if (pop) begin
          ref_dec(out_data, dd, s, e);
          check("dec_sec", s, (q[0].nerr == 1));
          check("dec_ded", e, (q[0].nerr == 2));
          if (q[0].nerr < 2) check("dec_data", dd, q[0].data);
          rx.push_back(out_data[DW-1:0]);
        end
      end
    end
    if (r) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        ent.cw   = ref_enc(d) ^ m;
        ent.data = d;
        ent.inj  = (m != '0);
        ent.nerr = $countones(m);
        q.push_back(ent);
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic [EW-1:0] ecc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit            a;
    bit            p;
    int            sent;
    logic [CW-1:0] one;
    logic [CW-1:0] m;
    int            b0;
    int            b1;

    fill_hpos();
    vecs[0] = '{32'h0000_0000, 7'h00};
    vecs[1] = '{32'h0000_0001, 7'h43};
    vecs[2] = '{32'h0000_0008, 7'h07};
    vecs[3] = '{32'h0000_0002, 7'h45};
    vecs[4] = '{32'h0000_0004, 7'h46};
    vecs[5] = '{32'h0000_0003, 7'h06};
    vecs[6] = '{32'h8000_0000, 7'h26};

    rst = 1'b1; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0; inj_mask = '0;
    @(negedge clk);
    cycle(1'b0, '0, 1'b0, 1'b1, '0, a, p);
    cycle(1'b0, '0, 1'b0, 1'b1, '0, a, p);
    model_on = 1'b1;

    // Reset state
    rst = 1'b0;
    #1;
    check("reset_out_vld", out_vld, 1'b0);
    check("reset_in_rdy", in_rdy, 1'b1);
    check("reset_out_data", out_data, '0);
`ifdef CBB_ECC_ENC_ERR_INJ_EN
    check("reset_out_inj", out_inj, 1'b0);
`endif

    // Known vectors, one cycle after acceptance
    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].data, 1'b1, 1'b0, '0, a, p);
      check("vec_out_vld", out_vld, 1'b1);
      check("vec_codeword", out_data, {vecs[i].ecc, vecs[i].data});
      cycle(1'b0, '0, 1'b1, 1'b0, '0, a, p);
    end

    // Backpressure: 8 incrementing words, out_rdy low on cycles 2..5
    rx.delete();
    sent = 0;
    for (int c = 0; c < 40 && rx.size() < 8; c++) begin
      cycle(sent < 8, DW'(100 + sent), !(c >= 2 && c <= 5), 1'b0, '0, a, p);
      if (a) sent++;
    end
    check("bp_count", rx.size(), 8);
    for (int i = 0; i < rx.size(); i++) check("bp_order", rx[i], 100 + i);

    // Reset while FULL: held words discarded
    rx.delete();
    cycle(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, '0, a, p);
    cycle(1'b1, 32'hAAAA_0002, 1'b0, 1'b0, '0, a, p);
    check("full_in_rdy", in_rdy, 1'b0);
    cycle(1'b1, 32'hAAAA_0003, 1'b0, 1'b1, '0, a, p);
    rst = 1'b0; in_vld = 1'b0;
    #1;
    check("midrst_out_vld", out_vld, 1'b0);
    check("midrst_in_rdy", in_rdy, 1'b1);
    check("midrst_out_data", out_data, '0);
    for (int c = 0; c < 4; c++) cycle(1'b0, '0, 1'b1, 1'b0, '0, a, p);
    check("midrst_no_emit", rx.size(), 0);

    // Random stream of 1000 words with random valid and backpressure
    rx.delete();
    sent = 0;
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      cycle($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 3) != 0, 1'b0, '0, a, p);
      if (a) sent++;
    end
    for (int c = 0; c < 10 && q.size() > 0; c++) cycle(1'b0, '0, 1'b1, 1'b0, '0, a, p);
    check("rand_count", rx.size(), 1000);

`ifdef CBB_ECC_ENC_ERR_INJ_EN
    // Single-bit injection at every codeword position, then double-bit masks
    one = 1;
    for (int pos = 0; pos < CW; pos++) begin
      cycle(1'b1, DW'($urandom), 1'b1, 1'b0, one << pos, a, p);
      check("inj1_flag", out_inj, 1'b1);
      cycle(1'b0, '0, 1'b1, 1'b0, '0, a, p);
    end
    for (int k = 0; k < 20; k++) begin
      b0 = $urandom_range(0, CW - 1);
      b1 = (b0 + $urandom_range(1, CW - 1)) % CW;
      m  = (one << b0) | (one << b1);
      cycle(1'b1, DW'($urandom), 1'b1, 1'b0, m, a, p);
      cycle(1'b0, '0, 1'b1, 1'b0, '0, a, p);
    end
    for (int c = 0; c < 4; c++) cycle(1'b0, '0, 1'b1, 1'b0, '0, a, p);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
